bus_mem_responder: RTL and testbench
====================================

# bus_mem_responder

Memory-side responder for the processor register/memory bus. It accepts single-cycle `read_q`/`write_q` requests from CPU-side register managers and services them against a local word-addressed memory window. It drives `is_bus_busy`, echoes the serviced address, returns read data and strobes `read_dn`/`write_dn`. It sits between the per-CPU register managers and the backing store and owns one address window `[BASE_ADDR, BASE_ADDR+DEPTH)`.

## Interface
Parameters:
- `BASE_ADDR`, default 0: first word address owned by this responder.
- `DEPTH`, default 64: words in the window; must be a power of two, at least 2.
- `LATENCY`, default 2: wait cycles between the accept cycle and the done cycle; range 0..15.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - `clk`  in  1  the single clock.
  - `rst`  in  1  asynchronous, active-high reset.
- `read_q`  in  1  read request strobe, valid for one cycle.
- `write_q`  in  1  write request strobe, valid for one cycle.
- `addr_req`  in  `ADDR_SIZE`  request address, sampled together with the strobe.
- `data_req`  in  `DATA_SIZE`  write data, sampled with `write_q`.
- `is_bus_busy`  out  1  high while a transaction is in flight, including the done cycle.
- `addr_echo`  out  `ADDR_SIZE`  address of the transaction in flight; initiators compare it against their own address.
- `data_rsp`  out  `DATA_SIZE`  read data, valid in the done cycle of a read.
- `read_dn`  out  1  one-cycle read-done strobe.
- `write_dn`  out  1  one-cycle write-done strobe.
- `overrun_err`  out  1  sticky flag; set when a request is dropped.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - An in-window strobe is accepted: its op, address and data are latched.
  - If LATENCY>0, go to WAIT with counter=LATENCY; otherwise go straight to DONE.
  - Out-of-window strobes are ignored: no busy, no error.
- WAIT: decrement the counter each cycle; go to DONE when it reaches 1.
- DONE:
  - Assert `read_dn` or `write_dn`.
  - Writes commit to memory on this edge.
  - Reads present `mem[addr_req-BASE_ADDR]`, with the offset truncated to log2(DEPTH) bits.
  - Next state: if the pending slot is valid, load it and go to WAIT/DONE; otherwise go to IDLE.
- Request arriving while not in IDLE: it goes into the single pending slot. If the slot is full, the request is dropped and `overrun_err` is set.
- `read_q` and `write_q` asserted in the same cycle:
  - The write is serviced first and the read goes to pending.
  - If pending is already occupied, the read is dropped and `overrun_err` is set.
- The pending slot cannot be loaded and drained in the same cycle. A request arriving in DONE with the slot empty is stored in the slot and starts immediately after.
- Read-after-write to the same address returns the newly written data, because service is strictly in order.

## Timing
- Reset values: `is_bus_busy`=0, `read_dn`=0, `write_dn`=0, `addr_echo`=0, `data_rsp`=0, `overrun_err`=0, FSM=IDLE, pending slot invalid. Memory contents are not reset.
- Reset asserted mid-transaction aborts it: no done strobe, no memory write.
- Accept edge is cycle 0. `is_bus_busy`=1 and `addr_echo` are valid from cycle 1 through cycle LATENCY+1. The done strobe fires in cycle LATENCY+1.
- Back-to-back transactions: `is_bus_busy` stays high with no idle gap, and `addr_echo` changes on the cycle after DONE.
- `data_rsp` holds its value until the next read's DONE. It reads 0 after reset.
- All outputs are registered.

## Structure
- `sizes.v` provides `ADDR_SIZE`/`DATA_SIZE`.
- New shared header `bus_codes.v` holds the FSM state codes (`BUS_ST_IDLE`, `BUS_ST_WAIT`, `BUS_ST_DONE`) and the op codes (`BUS_OP_RD`, `BUS_OP_WR`).
- Sub-module `bus_mem_array`: DEPTH×`DATA_SIZE` storage, synchronous write, asynchronous read.

## Test plan
- Reset, then a write with `addr_req`=BASE+5, `data_req`=32'hDEAD_BEEF, LATENCY=2 -> `is_bus_busy` high in cycles 1–3; `write_dn` in cycle 3; `addr_echo`=BASE+5.
- Read of BASE+5 after that write -> `read_dn` in cycle 3 with `data_rsp`=32'hDEAD_BEEF; `is_bus_busy` low in cycle 4.
- Same-cycle write(BASE+1, 32'h11) and read(BASE+1) -> `write_dn` in cycle 3, then `read_dn` in cycle 6 with `data_rsp`=32'h11; `is_bus_busy` continuous over cycles 1–6.
- Three requests in consecutive cycles while busy -> the first two are serviced in order; the third is dropped and `overrun_err`=1 from the next cycle and stays set.
- `read_q` with `addr_req`=BASE+DEPTH -> no busy, no done, no error.
- `rst` pulsed during WAIT -> all outputs return to their reset values immediately; no done strobe; a following read of the same address returns the old contents.

Source files
------------

// File: rtl/bus_mem_responder_pkg.sv
// bus_mem_responder_pkg
//   Shared definitions for the memory-side bus responder.
//   - ADDR_SIZE / DATA_SIZE : bus address and data widths.
//   - bus_state_t           : responder FSM state codes (IDLE, WAIT, DONE).
//   - bus_op_t              : transaction op codes (read, write).
//   - bus_req_t             : one captured request (op, address, write data).
//   - LAT_W                 : width of the latency counter (LATENCY 0..15).
package bus_mem_responder_pkg;

  localparam int ADDR_SIZE = 32;
  localparam int DATA_SIZE = 32;
  localparam int LAT_W     = 4;

  typedef enum logic [1:0] {
    BUS_ST_IDLE = 2'd0,
    BUS_ST_WAIT = 2'd1,
    BUS_ST_DONE = 2'd2
  } bus_state_t;

  typedef enum logic {
    BUS_OP_RD = 1'b0,
    BUS_OP_WR = 1'b1
  } bus_op_t;

  typedef struct packed {
    bus_op_t                op;
    logic [ADDR_SIZE-1:0]   addr;
    logic [DATA_SIZE-1:0]   data;
  } bus_req_t;

endpackage

// File: rtl/bus_mem_array.sv
// bus_mem_array
//   DEPTH x DATA_SIZE word storage with a synchronous write port and an
//   asynchronous read port. Contents are not reset.
//   Ports:
//     clk    in   clock for the write port
//     we     in   write enable, commits wdata at the rising edge
//     waddr  in   write word offset
//     wdata  in   write data
//     raddr  in   read word offset
//     rdata  out  combinational read data
module bus_mem_array
  import bus_mem_responder_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic [DATA_SIZE-1:0] rdata
);

  logic [DATA_SIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bus_mem_responder.sv
// bus_mem_responder
//   Memory-side responder for the processor register/memory bus. Accepts
//   single-cycle read/write strobes that fall inside its word window
//   [BASE_ADDR, BASE_ADDR+DEPTH), services them in order after LATENCY wait
//   cycles, and buffers at most one extra request in a pending slot.
//   Parameters:
//     BASE_ADDR  first word address owned by this responder
//     DEPTH      words in the window (power of two, >= 2)
//     LATENCY    wait cycles between accept and done (0..15)
//   Ports:
//     clk          in   clock
//     rst          in   asynchronous active-high reset
//     read_q       in   read request strobe (one cycle)
//     write_q      in   write request strobe (one cycle)
//     addr_req     in   request address
//     data_req     in   write data
//     is_bus_busy  out  high while a transaction is in flight, done cycle included
//     addr_echo    out  address of the transaction in flight
//     data_rsp     out  read data, updated in the done cycle of each read
//     read_dn      out  one-cycle read-done strobe
//     write_dn     out  one-cycle write-done strobe
//     overrun_err  out  sticky, set when a request is dropped
module bus_mem_responder
  import bus_mem_responder_pkg::*;
#(
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 read_q,
  input  logic                 write_q,
  input  logic [ADDR_SIZE-1:0] addr_req,
  input  logic [DATA_SIZE-1:0] data_req,
  output logic                 is_bus_busy,
  output logic [ADDR_SIZE-1:0] addr_echo,
  output logic [DATA_SIZE-1:0] data_rsp,
  output logic                 read_dn,
  output logic                 write_dn,
  output logic                 overrun_err
);

  localparam int               AW     = $clog2(DEPTH);
  localparam logic [ADDR_SIZE:0] WIN_LO = (ADDR_SIZE+1)'(BASE_ADDR);
  localparam logic [ADDR_SIZE:0] WIN_HI = (ADDR_SIZE+1)'(BASE_ADDR) + (ADDR_SIZE+1)'(DEPTH);
  localparam logic [LAT_W-1:0] LAT    = LAT_W'(LATENCY);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("bus_mem_responder: DEPTH must be a power of two >= 2");
    end
    if (LATENCY > 15) begin : g_bad_latency
      $error("bus_mem_responder: LATENCY must be in 0..15");
    end
  endgenerate

  bus_state_t           state;
  logic [LAT_W-1:0]     cnt;
  bus_op_t              cur_op;
  logic [DATA_SIZE-1:0] cur_data;
  bus_req_t             pend;
  logic                 pend_valid;

  logic                 in_win;
  logic                 wr_in;
  logic                 rd_in;
  bus_req_t             req_wr;
  bus_req_t             req_rd;

  logic                 start_valid;
  bus_req_t             start_req;
  logic                 drain;
  logic                 store;
  bus_req_t             store_req;
  logic                 drop;
  logic                 enter_done;
  bus_req_t             done_req;

  logic                 mem_we;
  logic [AW-1:0]        mem_off;
  logic [DATA_SIZE-1:0] mem_rdata;

  // Strobes outside the window are invisible to this responder.
  assign in_win = ({1'b0, addr_req} >= WIN_LO) && ({1'b0, addr_req} < WIN_HI);
  assign wr_in  = write_q && in_win;
  assign rd_in  = read_q && in_win;

  assign req_wr = '{op: BUS_OP_WR, addr: addr_req, data: data_req};
  assign req_rd = '{op: BUS_OP_RD, addr: addr_req, data: data_req};

  // Request routing. A transaction either starts directly (IDLE with an
  // incoming strobe, or the pending slot being drained), is parked in the
  // pending slot, or is dropped. When write and read arrive together the
  // write always wins the first position. The slot is never loaded in the
  // same cycle it is drained, so any arrival during a drain is dropped.
  always_comb begin
    start_valid = 1'b0;
    start_req   = req_wr;
    drain       = 1'b0;
    store       = 1'b0;
    store_req   = req_rd;
    drop        = 1'b0;

    unique case (state)
      BUS_ST_IDLE: begin
        if (pend_valid) begin
          start_valid = 1'b1;
          start_req   = pend;
          drain       = 1'b1;
          drop        = wr_in || rd_in;
        end else if (wr_in) begin
          start_valid = 1'b1;
          start_req   = req_wr;
          if (rd_in) begin
            store     = 1'b1;
            store_req = req_rd;
          end
        end else if (rd_in) begin
          start_valid = 1'b1;
          start_req   = req_rd;
        end
      end

      BUS_ST_WAIT, BUS_ST_DONE: begin
        if (state == BUS_ST_DONE && pend_valid) begin
          start_valid = 1'b1;
          start_req   = pend;
          drain       = 1'b1;
        end
        if (pend_valid) begin
          drop = wr_in || rd_in;
        end else if (wr_in) begin
          store     = 1'b1;
          store_req = req_wr;
          drop      = rd_in;
        end else if (rd_in) begin
          store     = 1'b1;
          store_req = req_rd;
        end
      end

      default: begin
      end
    endcase

    // DONE is entered either from the last WAIT cycle or, with no latency,
    // straight from the start of a transaction.
    enter_done = (state == BUS_ST_WAIT && cnt == LAT_W'(1)) ||
                 (start_valid && LATENCY == 0);
    done_req   = (state == BUS_ST_WAIT) ? '{op: cur_op, addr: addr_echo, data: cur_data}
                                        : start_req;
  end

  // The write lands on the same edge that raises write_dn, so a read queued
  // behind it always sees the new data. Reset suppresses the commit.
  assign mem_we  = enter_done && done_req.op == BUS_OP_WR && !rst;
  assign mem_off = AW'(done_req.addr - ADDR_SIZE'(BASE_ADDR));

  bus_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_off),
    .wdata (done_req.data),
    .raddr (mem_off),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BUS_ST_IDLE;
      cnt         <= '0;
      cur_op      <= BUS_OP_RD;
      cur_data    <= '0;
      pend        <= '0;
      pend_valid  <= 1'b0;
      is_bus_busy <= 1'b0;
      addr_echo   <= '0;
      data_rsp    <= '0;
      read_dn     <= 1'b0;
      write_dn    <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      read_dn  <= 1'b0;
      write_dn <= 1'b0;

      if (store) begin
        pend       <= store_req;
        pend_valid <= 1'b1;
      end else if (drain) begin
        pend_valid <= 1'b0;
      end

      if (drop) begin
        overrun_err <= 1'b1;
      end

      if (start_valid) begin
        cur_op      <= start_req.op;
        cur_data    <= start_req.data;
        addr_echo   <= start_req.addr;
        is_bus_busy <= 1'b1;
      end

      if (enter_done) begin
        state       <= BUS_ST_DONE;
        is_bus_busy <= 1'b1;
        read_dn     <= (done_req.op == BUS_OP_RD);
        write_dn    <= (done_req.op == BUS_OP_WR);
        if (done_req.op == BUS_OP_RD) begin
          data_rsp <= mem_rdata;
        end
      end else if (start_valid) begin
        state <= BUS_ST_WAIT;
        cnt   <= LAT;
      end else if (state == BUS_ST_WAIT) begin
        cnt <= cnt - LAT_W'(1);
      end else if (state == BUS_ST_DONE) begin
        state       <= BUS_ST_IDLE;
        is_bus_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_mem_responder.sv
// tb_bus_mem_responder
//   Directed, table-driven bench for bus_mem_responder with BASE_ADDR=16,
//   DEPTH=64, LATENCY=2. Each table row drives one cycle of inputs and lists
//   the outputs expected in the following cycle. Reset behaviour (initial and
//   mid-transaction) is covered by hand-written sequences.
module tb_bus_mem_responder;
  import bus_mem_responder_pkg::*;

  localparam int unsigned BASE  = 16;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned LAT   = 2;

  typedef struct packed {
    logic        busy;
    logic        rd_dn;
    logic        wr_dn;
    logic        err;
    logic [31:0] echo;
    logic [31:0] rsp;
  } out_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    out_t        exp;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 read_q = 1'b0;
  logic                 write_q = 1'b0;
  logic [ADDR_SIZE-1:0] addr_req = '0;
  logic [DATA_SIZE-1:0] data_req = '0;
  logic                 is_bus_busy;
  logic [ADDR_SIZE-1:0] addr_echo;
  logic [DATA_SIZE-1:0] data_rsp;
  logic                 read_dn;
  logic                 write_dn;
  logic                 overrun_err;

  int   tests_run = 0;
  int   tests_failed = 0;
  vec_t vecs[$];

  bus_mem_responder #(
    .BASE_ADDR (BASE),
    .DEPTH     (DEPTH),
    .LATENCY   (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .read_q      (read_q),
    .write_q     (write_q),
    .addr_req    (addr_req),
    .data_req    (data_req),
    .is_bus_busy (is_bus_busy),
    .addr_echo   (addr_echo),
    .data_rsp    (data_rsp),
    .read_dn     (read_dn),
    .write_dn    (write_dn),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  task automatic addVector(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic busy, input logic rd_dn,
                           input logic wr_dn, input logic err, input logic [31:0] echo,
                           input logic [31:0] rsp);
    vec_t v;
    v.rd   = rd;
    v.wr   = wr;
    v.addr = addr;
    v.data = data;
    v.exp  = '{busy: busy, rd_dn: rd_dn, wr_dn: wr_dn, err: err, echo: echo, rsp: rsp};
    vecs.push_back(v);
  endtask

  function automatic out_t sampleOutputs();
    out_t o;
    o = '{busy: is_bus_busy, rd_dn: read_dn, wr_dn: write_dn, err: overrun_err,
          echo: addr_echo, rsp: data_rsp};
    return o;
  endfunction

  task automatic checkOutput(input string name, input out_t exp);
    out_t act;
    act = sampleOutputs();
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got busy=%b rd_dn=%b wr_dn=%b err=%b echo=%h rsp=%h, expected busy=%b rd_dn=%b wr_dn=%b err=%b echo=%h rsp=%h",
               name, act.busy, act.rd_dn, act.wr_dn, act.err, act.echo, act.rsp,
               exp.busy, exp.rd_dn, exp.wr_dn, exp.err, exp.echo, exp.rsp);
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; outputs are sampled 1ns
  // after the rising edge that consumes them.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data);
    @(negedge clk);
    read_q   = rd;
    write_q  = wr;
    addr_req = addr;
    data_req = data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cycles;
    logic seen;
    logic got_done;

    //            rd wr addr      data          busy rdn wdn err echo      rsp
    // write BASE+5
    addVector(0, 1, 32'h15, 32'hDEADBEEF, 1, 0, 0, 0, 32'h15, 32'h0);
    addVector(0, 0, 32'h0,  32'h0,        1, 0, 0, 0, 32'h15, 32'h0);
    addVector(0, 0, 32'h0,  32'h0,        1, 0, 1, 0, 32'h15, 32'h0);
    addVector(0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 32'h15, 32'h0);
    // read BASE+5
    addVector(1, 0, 32'h15, 32'h0,        1, 0, 0, 0, 32'h15, 32'h0);
    addVector(0, 0, 32'h0,  32'h0,        1, 0, 0, 0, 32'h15, 32'h0);
    addVector(0, 0, 32'h0,  32'h0,        1, 1, 0, 0, 32'h15, 32'hDEADBEEF);
    addVector(0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 32'h15, 32'hDEADBEEF);
    // same-cycle write + read of BASE+1
    addVector(1, 1, 32'h11, 32'h11,       1, 0, 0, 0, 32'h11, 32'hDEADBEEF);
    addVector(0, 0, 32'h0,  32'h0,        1, 0, 0, 0, 32'h11, 32'hDEADBEEF);
    addVector(0, 0, 32'h0,  32'h0,        1, 0, 1, 0, 32'h11, 32'hDEADBEEF);
    addVector(0, 0, 32'h0,  32'h0,        1, 0, 0, 0, 32'h11, 32'hDEADBEEF);
    addVector(0, 0, 32'h0,  32'h0,        1, 0, 0, 0, 32'h11, 32'hDEADBEEF);
    addVector(0, 0, 32'h0,  32'h0,        1, 1, 0, 0, 32'h11, 32'h11);
    addVector(0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 32'h11, 32'h11);
    // out-of-window: BASE+DEPTH and BASE-1
    addVector(1, 0, 32'h50, 32'h0,        0, 0, 0, 0, 32'h11, 32'h11);
    addVector(0, 1, 32'h0F, 32'hBAD,      0, 0, 0, 0, 32'h11, 32'h11);
    // three consecutive requests: write, read (pending), write (dropped)
    addVector(0, 1, 32'h20, 32'hA5A5,     1, 0, 0, 0, 32'h20, 32'h11);
    addVector(1, 0, 32'h15, 32'h0,        1, 0, 0, 0, 32'h20, 32'h11);
    addVector(0, 1, 32'h21, 32'h77,       1, 0, 1, 1, 32'h20, 32'h11);
    addVector(0, 0, 32'h0,  32'h0,        1, 0, 0, 1, 32'h15, 32'h11);
    addVector(0, 0, 32'h0,  32'h0,        1, 0, 0, 1, 32'h15, 32'h11);
    addVector(0, 0, 32'h0,  32'h0,        1, 1, 0, 1, 32'h15, 32'hDEADBEEF);
    addVector(0, 0, 32'h0,  32'h0,        0, 0, 0, 1, 32'h15, 32'hDEADBEEF);
    // the first write of that burst landed
    addVector(1, 0, 32'h20, 32'h0,        1, 0, 0, 1, 32'h20, 32'hDEADBEEF);
    addVector(0, 0, 32'h0,  32'h0,        1, 0, 0, 1, 32'h20, 32'hDEADBEEF);
    addVector(0, 0, 32'h0,  32'h0,        1, 1, 0, 1, 32'h20, 32'hA5A5);
    addVector(0, 0, 32'h0,  32'h0,        0, 0, 0, 1, 32'h20, 32'hA5A5);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_held", '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_released", '0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Reset during WAIT aborts a write to BASE+5
    applyStimulus(1'b0, 1'b1, 32'h15, 32'h12345678);
    checkValue("abort_accept_busy", {31'b0, is_bus_busy}, 32'h1);
    @(negedge clk);
    write_q  = 1'b0;
    addr_req = '0;
    data_req = '0;
    #1;
    rst = 1'b1;
    #1;
    checkOutput("abort_async_reset", '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      seen = seen | is_bus_busy | read_dn | write_dn;
    end
    checkValue("abort_no_done", {31'b0, seen}, 32'h0);

    // Read back BASE+5: the aborted write must not have landed
    applyStimulus(1'b1, 1'b0, 32'h15, 32'h0);
    @(negedge clk);
    read_q   = 1'b0;
    addr_req = '0;
    cycles   = 1;
    got_done = read_dn;
    while (!got_done && cycles < 10) begin
      @(posedge clk);
      #1;
      cycles++;
      got_done = read_dn;
    end
    if (!got_done) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL abort_readback_timeout: no read_dn within %0d cycles, expected cycle 3", cycles);
    end else begin
      checkValue("abort_readback_cycle", cycles, 32'd3);
      checkValue("abort_readback_data", data_rsp, 32'hDEADBEEF);
      checkValue("abort_readback_err", {31'b0, overrun_err}, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
